// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue: circular FIFO of fetch packets with flush.
// Optional same-cycle fetch-to-decode bypass when empty: define IQ_BYPASS_EN.
module inst_queue #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Rest,
  input  logic             FetchValid,
  output logic             FetchReady,
  input  logic [31:0]      FetchPc,
  input  logic [31:0]      FetchInst1,
  input  logic [31:0]      FetchInst2,
  input  logic [31:0]      FetchInst3,
  input  logic [31:0]      FetchInst4,
  input  logic [3:0]       FetchMask,
  input  logic             Flush,
  output logic             DecodeValid,
  input  logic             DecodeReady,
  output logic [31:0]      OutDecodePc,
  output logic [31:0]      OutDecodeInst1,
  output logic [31:0]      OutDecodeInst2,
  output logic [31:0]      OutDecodeInst3,
  output logic [31:0]      OutDecodeInst4,
  output logic [3:0]       OutDecodeMask,
  output logic [CNT_W-1:0] QueueCount
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst1;
    logic [31:0] inst2;
    logic [31:0] inst3;
    logic [31:0] inst4;
    logic [3:0]  mask;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] count;

  entry_t fetch_pkt;
  entry_t head_pkt;
  logic   push;
  logic   pop;
  logic   bypass;
  logic   wr_en;
  logic   rd_en;

  assign fetch_pkt = '{pc: FetchPc, inst1: FetchInst1, inst2: FetchInst2,
                       inst3: FetchInst3, inst4: FetchInst4, mask: FetchMask};

  assign FetchReady = (count < CNT_W'(DEPTH)) && !Rest && !Flush;
  assign push       = FetchValid && FetchReady && (FetchMask != 4'b0000);

`ifdef IQ_BYPASS_EN
  assign bypass = (count == '0) && FetchValid && (FetchMask != 4'b0000) && !Flush && !Rest;
`else
  assign bypass = 1'b0;
`endif

  assign DecodeValid = ((count != '0) && !Flush) || bypass;
  assign pop         = DecodeValid && DecodeReady;
  // A bypassed packet consumed this cycle is neither written nor popped from storage.
  assign wr_en       = push && !(bypass && DecodeReady);
  assign rd_en       = pop && !bypass;

  always_comb begin
    head_pkt = '0;
    if (bypass)
      head_pkt = fetch_pkt;
    else if (DecodeValid)
      head_pkt = mem[rptr];
  end

  assign OutDecodePc    = head_pkt.pc;
  assign OutDecodeInst1 = head_pkt.inst1;
  assign OutDecodeInst2 = head_pkt.inst2;
  assign OutDecodeInst3 = head_pkt.inst3;
  assign OutDecodeInst4 = head_pkt.inst4;
  assign OutDecodeMask  = head_pkt.mask;
  assign QueueCount     = count;

  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (Flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en)
        wptr <= wptr + PTR_W'(1);
      if (rd_en)
        rptr <= rptr + PTR_W'(1);
      count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
  end

  always_ff @(posedge Clk) begin
    if (wr_en && !Flush)
      mem[wptr] <= fetch_pkt;
  end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: randomized traffic against a queue-based packet model.
module tb_inst_queue;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] i1;
    logic [31:0] i2;
    logic [31:0] i3;
    logic [31:0] i4;
    logic [3:0]  mask;
  } pkt_t;

  logic             Clk = 1'b0;
  logic             Rest = 1'b1;
  logic             FetchValid = 1'b0;
  logic             FetchReady;
  logic [31:0]      FetchPc = '0;
  logic [31:0]      FetchInst1 = '0;
  logic [31:0]      FetchInst2 = '0;
  logic [31:0]      FetchInst3 = '0;
  logic [31:0]      FetchInst4 = '0;
  logic [3:0]       FetchMask = '0;
  logic             Flush = 1'b0;
  logic             DecodeValid;
  logic             DecodeReady = 1'b0;
  logic [31:0]      OutDecodePc;
  logic [31:0]      OutDecodeInst1;
  logic [31:0]      OutDecodeInst2;
  logic [31:0]      OutDecodeInst3;
  logic [31:0]      OutDecodeInst4;
  logic [3:0]       OutDecodeMask;
  logic [CNT_W-1:0] QueueCount;

  inst_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rest(Rest),
    .FetchValid(FetchValid), .FetchReady(FetchReady),
    .FetchPc(FetchPc), .FetchInst1(FetchInst1), .FetchInst2(FetchInst2),
    .FetchInst3(FetchInst3), .FetchInst4(FetchInst4), .FetchMask(FetchMask),
    .Flush(Flush),
    .DecodeValid(DecodeValid), .DecodeReady(DecodeReady),
    .OutDecodePc(OutDecodePc), .OutDecodeInst1(OutDecodeInst1),
    .OutDecodeInst2(OutDecodeInst2), .OutDecodeInst3(OutDecodeInst3),
    .OutDecodeInst4(OutDecodeInst4), .OutDecodeMask(OutDecodeMask),
    .QueueCount(QueueCount)
  );

  always #5 Clk = ~Clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  pkt_t mq[$];
  pkt_t popped[$];
  pkt_t dut_o;

  assign dut_o = {OutDecodePc, OutDecodeInst1, OutDecodeInst2, OutDecodeInst3,
                  OutDecodeInst4, OutDecodeMask};

  function automatic pkt_t fetch_in();
    return {FetchPc, FetchInst1, FetchInst2, FetchInst3, FetchInst4, FetchMask};
  endfunction

  function automatic bit m_ready();
    return (mq.size() < DEPTH) && !Rest && !Flush;
  endfunction

  function automatic bit m_bypass();
`ifdef IQ_BYPASS_EN
    return (mq.size() == 0) && FetchValid && (FetchMask != 0) && !Flush && !Rest;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_valid();
    return ((mq.size() != 0) && !Flush && !Rest) || m_bypass();
  endfunction

  function automatic pkt_t m_head();
    if (!m_valid()) return '0;
    if (m_bypass()) return fetch_in();
    return mq[0];
  endfunction

  task automatic offer(input logic [31:0] pc, input logic [3:0] mask);
    FetchValid = 1'b1;
    FetchPc    = pc;
    FetchInst1 = $urandom;
    FetchInst2 = $urandom;
    FetchInst3 = $urandom;
    FetchInst4 = $urandom;
    FetchMask  = mask;
  endtask

  // Advance one clock edge and apply the queue rules to the model.
  task automatic tick();
    bit   byp, push, pop;
    pkt_t hd, in;
    byp  = m_bypass();
    push = FetchValid && m_ready() && (FetchMask != 0);
    pop  = m_valid() && DecodeReady;
    hd   = m_head();
    in   = fetch_in();
    @(posedge Clk);
    if (Rest || Flush) begin
      mq.delete();
    end else begin
      if (pop) popped.push_back(hd);
      if (pop && !byp) void'(mq.pop_front());
      if (push && !(byp && DecodeReady)) mq.push_back(in);
    end
    #1;
  endtask

  task automatic idle();
    FetchValid  = 1'b0;
    FetchMask   = '0;
    DecodeReady = 1'b0;
    Flush       = 1'b0;
  endtask

  task automatic drain();
    idle();
    DecodeReady = 1'b1;
    for (int c = 0; c < 2 * DEPTH && mq.size() != 0; c++) tick();
    DecodeReady = 1'b0;
    #1;
    n_cmp++;
    if (QueueCount !== '0) begin
      n_bad++;
      $display("FAIL drain_empty: QueueCount=%0d want 0", QueueCount);
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({FetchReady, DecodeValid, QueueCount} !== '0 || dut_o !== '0) begin
      n_bad++;
      $display("FAIL reset_state: rdy=%b vld=%b cnt=%0d out=%h want all 0",
               FetchReady, DecodeValid, QueueCount, dut_o);
    end
    tick();
    Rest = 1'b0;
    #1;
    n_cmp++;
    if (FetchReady !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release_ready: FetchReady=%b want 1", FetchReady);
    end
  endtask

  task automatic test_reset_mid();
    DecodeReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      offer(32'h1C000000 + 32'(i * 16), 4'hF);
      tick();
    end
    idle();
    #3;
    Rest = 1'b1;
    mq.delete();
    #1;
    n_cmp++;
    if (QueueCount !== '0 || DecodeValid !== 1'b0 || FetchReady !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_async: cnt=%0d vld=%b rdy=%b want 0/0/0",
               QueueCount, DecodeValid, FetchReady);
    end
    tick();
    Rest = 1'b0;
    offer(32'h1C000040, 4'h3);
    tick();
    idle();
    #1;
    n_cmp++;
    if (OutDecodePc !== 32'h1C000040 || dut_o !== m_head() || QueueCount !== 1) begin
      n_bad++;
      $display("FAIL reset_first_head: pc=%h cnt=%0d want pc=1c000040 cnt=1",
               OutDecodePc, QueueCount);
    end
    drain();
  endtask

  task automatic test_fill_drain();
    DecodeReady = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      offer(32'h1C000000 + 32'(i * 16), 4'hF);
      #1;
      n_cmp++;
      if (FetchReady !== 1'b1) begin
        n_bad++;
        $display("FAIL fill_ready_%0d: FetchReady=%b want 1", i, FetchReady);
      end
      tick();
    end
    offer(32'h1C000080, 4'hF);
    #1;
    n_cmp++;
    if (FetchReady !== 1'b0 || QueueCount !== CNT_W'(DEPTH)) begin
      n_bad++;
      $display("FAIL full: rdy=%b cnt=%0d want 0/%0d", FetchReady, QueueCount, DEPTH);
    end
    tick();
    n_cmp++;
    if (QueueCount !== CNT_W'(DEPTH)) begin
      n_bad++;
      $display("FAIL ninth_rejected: cnt=%0d want %0d", QueueCount, DEPTH);
    end
    // Pop while full with a fetch still offered: no same-cycle slot reuse.
    DecodeReady = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (i > 0) idle();
      DecodeReady = 1'b1;
      #1;
      n_cmp++;
      if (DecodeValid !== 1'b1 || OutDecodePc !== 32'h1C000000 + 32'(i * 16) ||
          dut_o !== m_head()) begin
        n_bad++;
        $display("FAIL drain_order_%0d: vld=%b pc=%h want pc=%h", i, DecodeValid,
                 OutDecodePc, 32'h1C000000 + 32'(i * 16));
      end
      if (i == 0) begin
        n_cmp++;
        if (FetchReady !== 1'b0) begin
          n_bad++;
          $display("FAIL full_pop_ready: FetchReady=%b want 0", FetchReady);
        end
      end
      tick();
      if (i == 0) begin
        n_cmp++;
        if (FetchReady !== 1'b1 || QueueCount !== CNT_W'(DEPTH - 1)) begin
          n_bad++;
          $display("FAIL ready_after_pop: rdy=%b cnt=%0d want 1/%0d",
                   FetchReady, QueueCount, DEPTH - 1);
        end
      end
    end
    drain();
  endtask

  task automatic test_simultaneous();
    logic [31:0] second_pc;
    DecodeReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      offer(32'h2000_0000 + 32'(i * 16), 4'h7);
      tick();
    end
    second_pc = mq[1].pc;
    offer(32'h2000_0100, 4'hF);
    DecodeReady = 1'b1;
    tick();
    idle();
    #1;
    n_cmp++;
    if (QueueCount !== 3 || OutDecodePc !== second_pc || dut_o !== m_head()) begin
      n_bad++;
      $display("FAIL push_pop_cnt3: cnt=%0d pc=%h want 3/%h", QueueCount, OutDecodePc, second_pc);
    end
    n_cmp++;
    if (mq[2].pc !== 32'h2000_0100) begin
      n_bad++;
      $display("FAIL push_pop_tail: model tail pc=%h want 20000100", mq[2].pc);
    end
    DecodeReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (dut_o !== m_head()) begin
        n_bad++;
        $display("FAIL push_pop_drain_%0d: out=%h want %h", i, dut_o, m_head());
      end
      tick();
    end
    drain();
  endtask

  task automatic test_flush();
    DecodeReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      offer(32'h3000_0000 + 32'(i * 16), 4'h1);
      tick();
    end
    offer(32'h3BAD_0000, 4'hF);
    DecodeReady = 1'b1;
    Flush = 1'b1;
    #1;
    n_cmp++;
    if (DecodeValid !== 1'b0 || FetchReady !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_cycle: vld=%b rdy=%b want 0/0", DecodeValid, FetchReady);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (QueueCount !== 0 || DecodeValid !== 1'b0 || OutDecodeInst1 !== 32'h0) begin
      n_bad++;
      $display("FAIL flush_after: cnt=%0d vld=%b inst1=%h want 0/0/0",
               QueueCount, DecodeValid, OutDecodeInst1);
    end
    DecodeReady = 1'b1;
    tick();
    n_cmp++;
    if (DecodeValid !== 1'b0 || OutDecodePc === 32'h3BAD_0000) begin
      n_bad++;
      $display("FAIL flush_no_ghost: vld=%b pc=%h want vld 0", DecodeValid, OutDecodePc);
    end
    idle();
  endtask

  task automatic test_wrap();
    logic [3:0] masks [4];
    int pushes = 0;
    int cyc    = 0;
    masks[0] = 4'b0001; masks[1] = 4'b0011; masks[2] = 4'b0111; masks[3] = 4'b1111;
    popped.delete();
    while (pushes < 20 && cyc < 400) begin
      if ($urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 6) == 0)
          offer(32'hDEAD_0000 + 32'(cyc), 4'b0000);
        else
          offer(32'h1C00_1000 + 32'(pushes * 16), masks[$urandom_range(0, 3)]);
      end else begin
        FetchValid = 1'b0;
      end
      DecodeReady = ($urandom_range(0, 2) != 0);
      #1;
      n_cmp++;
      if (DecodeValid !== m_valid() || dut_o !== m_head() ||
          FetchReady !== m_ready() || QueueCount !== CNT_W'(mq.size())) begin
        n_bad++;
        $display("FAIL wrap_cyc%0d: vld=%b out=%h rdy=%b cnt=%0d want %b %h %b %0d", cyc,
                 DecodeValid, dut_o, FetchReady, QueueCount, m_valid(), m_head(),
                 m_ready(), mq.size());
      end
      if (FetchValid && m_ready() && FetchMask != 0) pushes++;
      tick();
      cyc++;
    end
    n_cmp++;
    if (pushes < 20) begin
      n_bad++;
      $display("FAIL wrap_budget: pushes=%0d want 20", pushes);
    end
    drain();
    n_cmp++;
    if (popped.size() != 20) begin
      n_bad++;
      $display("FAIL wrap_popped: popped=%0d want 20", popped.size());
    end
    foreach (popped[k]) begin
      n_cmp++;
      if (popped[k].pc[31:16] === 16'hDEAD || popped[k].pc !== 32'h1C00_1000 + 32'(k * 16)) begin
        n_bad++;
        $display("FAIL wrap_order_%0d: pc=%h want %h", k, popped[k].pc,
                 32'h1C00_1000 + 32'(k * 16));
      end
    end
  endtask

  task automatic test_bypass();
    offer(32'h1C000100, 4'hF);
    DecodeReady = 1'b1;
    #1;
`ifdef IQ_BYPASS_EN
    n_cmp++;
    if (DecodeValid !== 1'b1 || dut_o !== fetch_in()) begin
      n_bad++;
      $display("FAIL bypass_same_cycle: vld=%b out=%h want 1/%h", DecodeValid, dut_o, fetch_in());
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (QueueCount !== 0 || DecodeValid !== 1'b0) begin
      n_bad++;
      $display("FAIL bypass_count: cnt=%0d vld=%b want 0/0", QueueCount, DecodeValid);
    end
`else
    n_cmp++;
    if (DecodeValid !== 1'b0 || dut_o !== '0) begin
      n_bad++;
      $display("FAIL nobypass_same_cycle: vld=%b out=%h want 0/0", DecodeValid, dut_o);
    end
    tick();
    FetchValid = 1'b0;
    #1;
    n_cmp++;
    if (QueueCount !== 1 || DecodeValid !== 1'b1 || OutDecodePc !== 32'h1C000100) begin
      n_bad++;
      $display("FAIL nobypass_next: cnt=%0d vld=%b pc=%h want 1/1/1c000100",
               QueueCount, DecodeValid, OutDecodePc);
    end
    tick();
    n_cmp++;
    if (QueueCount !== 0 || DecodeValid !== 1'b0) begin
      n_bad++;
      $display("FAIL nobypass_drained: cnt=%0d vld=%b want 0/0", QueueCount, DecodeValid);
    end
`endif
    idle();
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_fill_drain();
    test_simultaneous();
    test_flush();
    test_wrap();
    test_bypass();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
